rvv_wb_collector: RTL

Result-side counterpart of the vector ALU lanes. Accepts lane-width result chunks, each tagged with a bit index, and assembles them into a VLEN-wide destination register image. When a register of the group is complete, it issues one write to the vector register file through a valid/ready handshake. It steps through LMUL register groups and signals completion of the instruction.

---
 rtl/rvv_wb_collector.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rvv_wb_collector.sv
`default_nettype none
// =============================================================================
// Module   : rvv_wb_collector
// Brief    : Assembles lane-width result chunks into VLEN-wide register images
//            and writes each register of an LMUL group to the VRF.
//            Define RVV_WB_TAIL_MASK_EN for tail-undisturbed byte enables.
// Revision : 1.0 - initial release
// =============================================================================
module rvv_wb_collector #(
    parameter int unsigned VLEN       = 10'd128,
    parameter int unsigned LANE_WIDTH = 3'b011
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [4:0]        vd_base,
    input  logic [10:0]       vl,
    input  logic [2:0]        vsew,
    input  logic [3:0]        nregs,
    input  logic              res_valid,
    input  logic [63:0]       res_data,
    input  logic [9:0]        res_index,
    output logic              res_ready,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [4:0]        wr_addr,
    output logic [VLEN-1:0]   wr_data,
    output logic [VLEN/8-1:0] wr_be,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned     c_W         = 1 << LANE_WIDTH;
    localparam int unsigned     c_NB        = VLEN / 8;
    localparam logic [13:0]     c_VLEN14    = 14'(VLEN);
    localparam logic [10:0]     c_VLEN11    = 11'(VLEN);
    localparam logic [10:0]     c_W11       = 11'(c_W);
    localparam logic [13:0]     c_W14       = 14'(c_W);
    localparam logic [VLEN-1:0] c_LANE_ONES = {VLEN{1'b1}} >> (VLEN - c_W);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_WRITE   = 2'd2;
    localparam logic [1:0] c_FINISH  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [13:0]     r_remaining;
    logic [13:0]     r_reg_bits;
    logic [3:0]      r_reg_cnt;
    logic [3:0]      r_nregs;
    logic [4:0]      r_cur_addr;
    logic [VLEN-1:0] r_buf;
    logic            r_err;

    logic [13:0]     w_total;
    logic [13:0]     w_target;
    logic [13:0]     w_rem_after;
    logic [13:0]     w_reg_bits_nxt;
    logic [10:0]     w_idx_end;
    logic            w_in_range;
    logic            w_res_hs;
    logic            w_accept;
    logic            w_last_reg;
    logic [VLEN-1:0] w_lane_mask;
    logic [VLEN-1:0] w_lane_data;
    logic            w_unused;

    assign w_unused       = &{1'b0, res_data};
    assign w_total        = 14'({6'd0, vl} << ({1'b0, vsew} + 4'd3));
    assign w_target       = (r_remaining < c_VLEN14) ? r_remaining : c_VLEN14;
    assign w_rem_after    = r_remaining - w_target;
    assign w_idx_end      = {1'b0, res_index} + c_W11;
    assign w_in_range     = (w_idx_end <= c_VLEN11);
    assign w_res_hs       = (r_state == c_COLLECT) && res_valid;
    assign w_accept       = w_res_hs && w_in_range;
    assign w_reg_bits_nxt = r_reg_bits + (w_accept ? c_W14 : 14'd0);
    assign w_last_reg     = (w_rem_after == 14'd0) || ((r_reg_cnt + 4'd1) == r_nregs);
    assign w_lane_mask    = c_LANE_ONES << res_index;
    assign w_lane_data    = VLEN'(res_data[c_W-1:0]) << res_index;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_total == 14'd0) ? c_FINISH : c_COLLECT;
                end
            end
            c_COLLECT: begin
                if (w_reg_bits_nxt >= w_target) begin
                    w_state_nxt = c_WRITE;
                end
            end
            c_WRITE: begin
                if (wr_ready) begin
                    w_state_nxt = w_last_reg ? c_FINISH : c_COLLECT;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

`ifdef RVV_WB_TAIL_MASK_EN
    localparam logic [c_NB-1:0] c_BYTE_ONES = {c_NB{1'b1}} >> (c_NB - c_W / 8);

    logic [c_NB-1:0] r_mask;
    logic [c_NB-1:0] w_byte_mask;

    assign w_byte_mask = c_BYTE_ONES << res_index[9:3];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mask <= '0;
        end else if ((r_state == c_IDLE) && start) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask <= r_mask | w_byte_mask;
        end else if ((r_state == c_WRITE) && wr_ready) begin
            r_mask <= '0;
        end
    end

    assign wr_be = r_mask;
`else
    // Tail-agnostic: full enables, unwritten bytes are zero because the buffer is cleared per register.
    assign wr_be = wr_valid ? {c_NB{1'b1}} : '0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_remaining <= '0;
            r_reg_bits  <= '0;
            r_reg_cnt   <= '0;
            r_nregs     <= '0;
            r_cur_addr  <= '0;
            r_buf       <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_remaining <= w_total;
                        r_reg_bits  <= '0;
                        r_reg_cnt   <= '0;
                        r_nregs     <= nregs;
                        r_cur_addr  <= vd_base;
                        r_buf       <= '0;
                        r_err       <= 1'b0;
                    end
                end
                c_COLLECT: begin
                    if (w_res_hs) begin
                        if (w_in_range) begin
                            r_buf      <= (r_buf & ~w_lane_mask) | w_lane_data;
                            r_reg_bits <= w_reg_bits_nxt;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_WRITE: begin
                    if (wr_ready) begin
                        r_remaining <= w_rem_after;
                        r_reg_cnt   <= r_reg_cnt + 4'd1;
                        r_cur_addr  <= r_cur_addr + 5'd1;
                        r_buf       <= '0;
                        r_reg_bits  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_ready = (r_state == c_COLLECT);
    assign wr_valid  = (r_state == c_WRITE);
    assign wr_addr   = r_cur_addr;
    assign wr_data   = r_buf;
    assign busy      = (r_state == c_COLLECT) || (r_state == c_WRITE);
    assign done      = (r_state == c_FINISH);
    assign err       = r_err;

endmodule
`default_nettype wire
